branch_redirect_ctrl: RTL and testbench

Execute-stage controller that sequences the branch/jump datapath of the MIPS pipeline. It takes the EX-stage control flags, the ALU zero flag and the candidate target addresses: the branch target from the EX branch-target adder, the jump target and the register target. From these it resolves whether the instruction is taken, issues a one-cycle PC redirect to the fetch stage and flushes the wrong-path instructions for a programmable number of cycles. Saturating branch/taken counters feed the debug unit.

---
 rtl/branch_redirect_ctrl.sv | 146 ++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch/jump resolver: issues a registered one-cycle PC redirect,
// flushes wrong-path IF/ID and ID/EX for flush_cycles unstalled cycles, and keeps branch statistics.
module branch_redirect_ctrl #(
  parameter int len          = 32,
  parameter int flush_cycles = 1,
  parameter int cnt_len      = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_branch,
  input  logic               i_branch_ne,
  input  logic               i_jump,
  input  logic               i_jump_reg,
  input  logic               i_zero,
  input  logic [len-1:0]     i_branch_target,
  input  logic [len-1:0]     i_jump_target,
  input  logic [len-1:0]     i_reg_target,
  input  logic               i_cnt_clear,
  output logic               o_redirect,
  output logic [len-1:0]     o_pc_target,
  output logic               o_flush_if_id,
  output logic               o_flush_id_ex,
  output logic               o_busy,
  output logic [cnt_len-1:0] o_branch_count,
  output logic [cnt_len-1:0] o_taken_count
);

  if (flush_cycles < 1 || flush_cycles > 3) begin : g_bad_flush_cycles
    $error("flush_cycles must be in 1..3");
  end

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [1:0] FLUSH_INIT = 2'(flush_cycles);

  state_t             state_p1, state_nxt;
  logic [1:0]         flush_cnt_p1, flush_cnt_nxt;
  logic               redirect_p1, redirect_nxt;
  logic               flush_p1, flush_nxt;
  logic [len-1:0]     pc_target_p1, pc_target_nxt;
  logic [cnt_len-1:0] branch_cnt_p1, branch_cnt_nxt;
  logic [cnt_len-1:0] taken_cnt_p1, taken_cnt_nxt;

  logic               res_p0;
  logic               taken_p0;
  logic               cond_br_p0;
  logic [len-1:0]     target_p0;

  function automatic logic [cnt_len-1:0] sat_inc(input logic [cnt_len-1:0] v);
    sat_inc = (&v) ? v : v + cnt_len'(1);
  endfunction

  // p0: resolve the EX instruction (only while IDLE and not frozen)
  always_comb begin
    res_p0     = i_valid & ~i_stall & (state_p1 == IDLE);
    cond_br_p0 = i_branch | i_branch_ne;
    taken_p0   = res_p0 & (i_jump_reg | i_jump |
                           (i_branch & i_zero) | (i_branch_ne & ~i_zero));
    if (i_jump_reg)
      target_p0 = i_reg_target;
    else if (i_jump)
      target_p0 = i_jump_target;
    else
      target_p0 = i_branch_target;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_p1     <= IDLE;
      flush_cnt_p1 <= 2'd0;
    end else begin
      state_p1     <= state_nxt;
      flush_cnt_p1 <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_p1;
    flush_cnt_nxt = flush_cnt_p1;
    case (state_p1)
      IDLE: begin
        if (taken_p0) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_INIT;
        end
      end
      FLUSH: begin
        if (!i_stall) begin
          flush_cnt_nxt = flush_cnt_p1 - 2'd1;
          if (flush_cnt_p1 == 2'd1)
            state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        flush_cnt_nxt = 2'd0;
      end
    endcase
  end

  // Next values of the registered outputs; redirect can only fire out of IDLE, so it never repeats
  always_comb begin
    redirect_nxt   = (state_p1 == IDLE) & taken_p0;
    flush_nxt      = (state_nxt == FLUSH);
    pc_target_nxt  = taken_p0 ? target_p0 : pc_target_p1;
    branch_cnt_nxt = branch_cnt_p1;
    taken_cnt_nxt  = taken_cnt_p1;
    if (i_cnt_clear) begin
      branch_cnt_nxt = '0;
      taken_cnt_nxt  = '0;
    end else begin
      if (res_p0 & cond_br_p0)
        branch_cnt_nxt = sat_inc(branch_cnt_p1);
      if (taken_p0)
        taken_cnt_nxt = sat_inc(taken_cnt_p1);
    end
  end

  // p1: registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      redirect_p1   <= 1'b0;
      flush_p1      <= 1'b0;
      pc_target_p1  <= '0;
      branch_cnt_p1 <= '0;
      taken_cnt_p1  <= '0;
    end else begin
      redirect_p1   <= redirect_nxt;
      flush_p1      <= flush_nxt;
      pc_target_p1  <= pc_target_nxt;
      branch_cnt_p1 <= branch_cnt_nxt;
      taken_cnt_p1  <= taken_cnt_nxt;
    end
  end

  assign o_redirect     = redirect_p1;
  assign o_pc_target    = pc_target_p1;
  assign o_flush_if_id  = flush_p1;
  assign o_flush_id_ex  = flush_p1;
  assign o_busy         = (state_p1 == FLUSH);
  assign o_branch_count = branch_cnt_p1;
  assign o_taken_count  = taken_cnt_p1;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_redirect_ctrl;

  localparam int LEN  = 32;
  localparam int FC   = 3;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            valid, stall, br, br_ne, jmp, jmp_reg, zero, cnt_clear;
  logic [LEN-1:0]  br_tgt, j_tgt, r_tgt;
  logic            redirect, flush_if_id, flush_id_ex, busy;
  logic [LEN-1:0]  pc_target;
  logic [CW-1:0]   branch_count, taken_count;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  // model state
  int             m_left;
  bit             m_red;
  logic [LEN-1:0] m_tgt;
  int             m_bc, m_tc;

  branch_redirect_ctrl #(.len(LEN), .flush_cycles(FC), .cnt_len(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
    .i_branch(br), .i_branch_ne(br_ne), .i_jump(jmp), .i_jump_reg(jmp_reg),
    .i_zero(zero), .i_branch_target(br_tgt), .i_jump_target(j_tgt),
    .i_reg_target(r_tgt), .i_cnt_clear(cnt_clear),
    .o_redirect(redirect), .o_pc_target(pc_target),
    .o_flush_if_id(flush_if_id), .o_flush_id_ex(flush_id_ex), .o_busy(busy),
    .o_branch_count(branch_count), .o_taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: remaining unstalled flush cycles, pending redirect, last target, saturating counts
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_red = 1'b0; m_tgt = '0; m_bc = 0; m_tc = 0;
    end else begin
      bit res, tk;
      res = valid && !stall && (m_left == 0);
      tk  = res && (jmp_reg || jmp || (br && zero) || (br_ne && !zero));
      if (cnt_clear) begin
        m_bc = 0; m_tc = 0;
      end else begin
        if (res && (br || br_ne) && m_bc < MAXC) m_bc++;
        if (tk && m_tc < MAXC) m_tc++;
      end
      m_red = tk;
      if (tk) begin
        m_left = FC;
        m_tgt  = jmp_reg ? r_tgt : (jmp ? j_tgt : br_tgt);
      end else if (m_left > 0 && !stall) begin
        m_left--;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("redirect",     {31'd0, redirect},    {31'd0, m_red});
      check("flush_if_id",  {31'd0, flush_if_id}, {31'd0, m_left > 0});
      check("flush_id_ex",  {31'd0, flush_id_ex}, {31'd0, m_left > 0});
      check("busy",         {31'd0, busy},        {31'd0, m_left > 0});
      check("pc_target",    pc_target,            m_tgt);
      check("branch_count", 32'(branch_count),    32'(m_bc));
      check("taken_count",  32'(taken_count),     32'(m_tc));
    end
  end

  task automatic idle_inputs();
    valid = 0; stall = 0; br = 0; br_ne = 0; jmp = 0; jmp_reg = 0; zero = 0;
    cnt_clear = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
    check({tag, "_flush"},    {30'd0, flush_if_id, flush_id_ex}, 32'd0);
    check({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check({tag, "_pc"},       pc_target, 32'd0);
    check({tag, "_counts"},   {16'd0, branch_count, taken_count}, 32'd0);
  endtask

  initial begin
    int fl, red, first_red;
    idle_inputs();
    br_tgt = '0; j_tgt = '0; r_tgt = '0;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    #1 check_all_zero("reset_init");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // beq taken
    valid = 1; br = 1; zero = 1; br_tgt = 32'h0000_0040;
    @(negedge clk);
    idle_inputs();
    check("beq_redirect", {31'd0, redirect}, 32'd1);
    check("beq_pc", pc_target, 32'h40);
    fl = flush_if_id ? 1 : 0;
    repeat (6) begin
      @(negedge clk);
      if (flush_if_id) fl++;
    end
    check("beq_flush_len", 32'(fl), 32'(FC));
    check("beq_counts", {16'd0, branch_count, taken_count}, 32'h0101);

    // bne not taken, beq not taken after a clear
    cnt_clear = 1;
    @(negedge clk);
    cnt_clear = 0; valid = 1; br_ne = 1; zero = 1;
    @(negedge clk);
    check("bne_nt_redirect", {31'd0, redirect}, 32'd0);
    br_ne = 0; br = 1; zero = 0;
    @(negedge clk);
    idle_inputs();
    check("beq_nt_flush", {31'd0, flush_if_id}, 32'd0);
    check("nt_counts", {16'd0, branch_count, taken_count}, 32'h0200);

    // target priority
    valid = 1; jmp_reg = 1; jmp = 1; br = 1; zero = 1;
    r_tgt = 32'h100; j_tgt = 32'h200; br_tgt = 32'h300;
    @(negedge clk);
    idle_inputs();
    check("prio_pc", pc_target, 32'h100);
    repeat (FC) @(negedge clk);

    // stall before resolution and inside the flush
    fl = 0; red = 0; first_red = -1;
    j_tgt = 32'h0000_0A00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (flush_if_id) fl++;
      if (redirect) begin
        red++;
        if (first_red < 0) first_red = k;
      end
      valid = (k <= 3); jmp = (k <= 3);
      stall = (k < 3) || (k == 5) || (k == 6);
    end
    idle_inputs();
    check("stall_redirect_at", 32'(first_red), 32'd4);
    check("stall_redirect_pulses", 32'(red), 32'd1);
    check("stall_flush_len", 32'(fl), 32'd5);
    check("stall_pc", pc_target, 32'h0000_0A00);

    // asynchronous reset mid-flush
    @(negedge clk);
    valid = 1; jmp = 1; j_tgt = 32'h0000_0C00;
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle_busy", {31'd0, busy}, 32'd0);

    // taken counter saturation
    for (int n = 0; n <= MAXC; n++) begin
      valid = 1; jmp = 1; j_tgt = $urandom;
      @(negedge clk);
      idle_inputs();
      repeat (FC) @(negedge clk);
      if (n == MAXC - 1) check("taken_reach_max", 32'(taken_count), 32'(MAXC));
    end
    check("taken_sat", 32'(taken_count), 32'(MAXC));
    valid = 1; br = 1; zero = 1; cnt_clear = 1; br_tgt = 32'h44;
    @(negedge clk);
    idle_inputs();
    check("clear_with_taken_redirect", {31'd0, redirect}, 32'd1);
    check("clear_with_taken_count", {16'd0, branch_count, taken_count}, 32'd0);
    repeat (FC) @(negedge clk);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      valid     = ($urandom_range(0, 9) < 7);
      stall     = ($urandom_range(0, 9) < 2);
      br        = ($urandom_range(0, 3) == 0);
      br_ne     = ($urandom_range(0, 3) == 0);
      jmp       = ($urandom_range(0, 5) == 0);
      jmp_reg   = ($urandom_range(0, 7) == 0);
      zero      = $urandom_range(0, 1);
      cnt_clear = ($urandom_range(0, 49) == 0);
      br_tgt    = $urandom;
      j_tgt     = $urandom;
      r_tgt     = $urandom;
      @(negedge clk);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
